cmd_msg_encoder: RTL and testbench
==================================

CMD_MSG_ENCODER -- requirements
Module: cmd_msg_encoder

Interface
REQ-001 The block SHALL expose parameter GAP_CYCLES, default 50000, setting the idle clk_50M cycles enforced between frames (1 ms).
REQ-002 The block SHALL expose these ports:
- clk_50M, input, 1, sole clock
- reset, input, 1, synchronous active-high reset
- cmd_valid, input, 1, command offered
- cmd_type, input, 2, 00=EU fault, 01=CU fault, 10=RU fault, 11=pick block
- cmd_loc, input, 2, location index 0..3
- cmd_ready, output, 1, pending slot empty
- tx_done, input, 1, one-cycle pulse from uart_tx marking the end of a byte
- data_send, output, 1, one-cycle byte-launch strobe to uart_tx
- msg, output, 8, byte to uart_tx
- busy, output, 1, frame in progress or gap running
- frames_sent, output, 8, count of completed frames

Function
REQ-003 The block SHALL have one clock (clk_50M) and a synchronous, active-high reset named reset.
REQ-004 Frame bytes SHALL be sent in this order:
- '#' (0x23)
- class byte: 'F' (0x46) for fault, 'P' (0x50) for pick
- unit byte: 'E' (0x45), 'C' (0x43), 'R' (0x52), or 'B' (0x42) for pick
- '-' (0x2D)
- location byte: 0x30+cmd_loc
- '#' (0x23)
REQ-005 A one-entry pending buffer SHALL capture cmd_type and cmd_loc on any edge where cmd_valid=1 and cmd_ready=1; cmd_ready SHALL equal NOT pending_valid.
REQ-006 The FSM SHALL have the states IDLE, SEND, WAIT_DONE and GAP.
REQ-007 In IDLE with pending_valid=1, the block SHALL copy pending into the active register, clear pending_valid, and enter SEND on the next edge.
REQ-008 If a new command is accepted on the same edge as the IDLE transfer, pending SHALL hold the new command and active SHALL hold the old one; no command is lost.
REQ-009 SEND SHALL last exactly one cycle, with data_send=1 and msg equal to the current byte, then go to WAIT_DONE.
REQ-010 msg SHALL stay stable from the SEND cycle until the tx_done that ends that byte.
REQ-011 In WAIT_DONE, a tx_done pulse SHALL advance the byte index and return to SEND, or enter GAP if the last byte is done.
REQ-012 tx_done received in any state other than WAIT_DONE SHALL be ignored.
REQ-013 GAP SHALL count GAP_CYCLES cycles and then enter IDLE.
REQ-014 frames_sent SHALL increment on entry to GAP and wrap from 255 to 0.
REQ-015 busy SHALL be 1 in SEND, WAIT_DONE and GAP, and 0 in IDLE.
REQ-016 Latency from acceptance (pending empty, FSM in IDLE) to the first data_send SHALL be exactly 2 cycles.
REQ-017 The byte index counter SHALL be 3 bits and SHALL never exceed frame length minus 1.

Reset
REQ-018 While reset=1 the block SHALL force:
- state=IDLE
- pending_valid=0
- byte index=0
- gap counter=0
- frames_sent=0x00
- data_send=0
- msg=0x00
- busy=0
- cmd_ready=1
REQ-019 Reset asserted mid-frame SHALL abort the frame immediately; any partially sent frame is not counted and the pending command is discarded.
REQ-020 Reset SHALL take priority over cmd_valid and tx_done on the same edge.

Configuration
REQ-021 With macro CMD_MSG_CHECKSUM_EN defined, a checksum byte SHALL be inserted between the location byte and the final '#', giving a 7-byte frame.
REQ-022 The checksum byte SHALL equal 0x40 | ((class ^ unit ^ 0x2D ^ location) & 0x3F), so it never equals 0x23.
REQ-023 Without CMD_MSG_CHECKSUM_EN, the frame SHALL be 6 bytes and contain no checksum logic.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then cmd_type=00, cmd_loc=1, and tx_done 10 cycles after each data_send -> msg sequence 23,46,45,2D,31,23; first data_send 2 cycles after acceptance; frames_sent=1 after the last tx_done.
- Checksum build, cmd_type=00, cmd_loc=1 -> sequence 23,46,45,2D,31,5F,23.
- Pick command cmd_type=11, cmd_loc=3, then a second command offered during the frame -> cmd_ready drops after the second accept; the second frame 23,50,42,2D,33,23 starts only after GAP_CYCLES of idle.
- Spurious tx_done in IDLE and GAP, plus a double tx_done in WAIT_DONE -> no byte skipped after the first pulse; spurious pulses have no effect.
- Reset asserted after the third data_send -> next cycle all outputs at reset values; frames_sent unchanged at 0; a fresh command restarts from '#'.
- 256 back-to-back frames -> frames_sent wraps to 0x00.

Source files
------------

// File: rtl/cmd_msg_encoder.sv
// Frames a fault/pick command as "#<class><unit>-<loc>#" for a byte-wide UART transmitter.
// Define CMD_MSG_CHECKSUM_EN to insert a checksum byte before the closing '#'.
module cmd_msg_encoder #(
  parameter int GAP_CYCLES = 50000
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_type,
  input  logic [1:0] cmd_loc,
  output logic       cmd_ready,
  input  logic       tx_done,
  output logic       data_send,
  output logic [7:0] msg,
  output logic       busy,
  output logic [7:0] frames_sent
);

`ifdef CMD_MSG_CHECKSUM_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_pend_valid;
  logic [1:0]       r_pend_type;
  logic [1:0]       r_pend_loc;
  logic [1:0]       r_act_type;
  logic [1:0]       r_act_loc;
  logic [2:0]       r_byte_idx;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [7:0]       r_frames;

  logic             w_accept;
  logic             w_xfer;
  logic             w_byte_done;
  logic             w_last_byte;
  logic             w_gap_done;
  logic [7:0]       w_class;
  logic [7:0]       w_unit;
  logic [7:0]       w_loc;
  logic [7:0]       w_byte;

  assign cmd_ready   = ~r_pend_valid;
  assign frames_sent = r_frames;

  // Accept only into an empty slot, so an accept and an IDLE transfer never collide.
  assign w_accept    = cmd_valid & ~r_pend_valid;
  assign w_xfer      = (r_state == IDLE) & r_pend_valid;
  assign w_last_byte = (r_byte_idx == LAST_IDX);
  assign w_byte_done = (r_state == WAIT_DONE) & tx_done;
  assign w_gap_done  = (r_state == GAP) & (r_gap_cnt == GAP_LAST);

  assign w_class = (r_act_type == 2'b11) ? 8'h50 : 8'h46;
  assign w_loc   = {6'b001100, r_act_loc};

  always_comb begin
    w_unit = 8'h42;
    case (r_act_type)
      2'b00:   w_unit = 8'h45;
      2'b01:   w_unit = 8'h43;
      2'b10:   w_unit = 8'h52;
      default: w_unit = 8'h42;
    endcase
  end

`ifdef CMD_MSG_CHECKSUM_EN
  logic [7:0] w_csum;
  // Forcing bit 6 keeps the checksum clear of the '#' delimiter.
  assign w_csum = 8'h40 | ((w_class ^ w_unit ^ 8'h2D ^ w_loc) & 8'h3F);
`endif

  always_comb begin
    w_byte = 8'h00;
    case (r_byte_idx)
      3'd0:    w_byte = 8'h23;
      3'd1:    w_byte = w_class;
      3'd2:    w_byte = w_unit;
      3'd3:    w_byte = 8'h2D;
      3'd4:    w_byte = w_loc;
`ifdef CMD_MSG_CHECKSUM_EN
      3'd5:    w_byte = w_csum;
      3'd6:    w_byte = 8'h23;
`else
      3'd5:    w_byte = 8'h23;
`endif
      default: w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    data_send    = 1'b0;
    busy         = 1'b1;
    msg          = 8'h00;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (r_pend_valid) w_state_next = SEND;
      end
      SEND: begin
        data_send    = 1'b1;
        msg          = w_byte;
        w_state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        msg = w_byte;
        if (tx_done) w_state_next = w_last_byte ? GAP : SEND;
      end
      GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_type  <= 2'b00;
      r_pend_loc   <= 2'b00;
      r_act_type   <= 2'b00;
      r_act_loc    <= 2'b00;
      r_byte_idx   <= 3'd0;
      r_gap_cnt    <= '0;
      r_frames     <= 8'h00;
    end else begin
      if (w_accept) begin
        r_pend_type <= cmd_type;
        r_pend_loc  <= cmd_loc;
      end
      r_pend_valid <= w_accept | (r_pend_valid & ~w_xfer);

      if (w_xfer) begin
        r_act_type <= r_pend_type;
        r_act_loc  <= r_pend_loc;
        r_byte_idx <= 3'd0;
      end else if (w_byte_done) begin
        r_byte_idx <= w_last_byte ? 3'd0 : r_byte_idx + 3'd1;
      end

      if (r_state == GAP) begin
        r_gap_cnt <= w_gap_done ? '0 : r_gap_cnt + GAP_W'(1);
      end

      // A frame counts only once its closing byte has been acknowledged.
      if (w_byte_done && w_last_byte) begin
        r_frames <= r_frames + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_msg_encoder.sv
// Directed bench for cmd_msg_encoder: frame content, latency, gap, spurious tx_done, reset, wrap.
// Expected frames follow CMD_MSG_CHECKSUM_EN when it is defined for the build.
module tb_cmd_msg_encoder;

  localparam int GAP  = 20;
  localparam int MAXW = 200;
`ifdef CMD_MSG_CHECKSUM_EN
  localparam int N = 7;
  localparam logic [55:0] F_E1 = {8'h23, 8'h46, 8'h45, 8'h2D, 8'h31, 8'h5F, 8'h23};
  localparam logic [55:0] F_B3 = {8'h23, 8'h50, 8'h42, 8'h2D, 8'h33, 8'h4C, 8'h23};
  localparam logic [55:0] F_C0 = {8'h23, 8'h46, 8'h43, 8'h2D, 8'h30, 8'h58, 8'h23};
`else
  localparam int N = 6;
  localparam logic [55:0] F_E1 = {8'h23, 8'h46, 8'h45, 8'h2D, 8'h31, 8'h23, 8'h00};
  localparam logic [55:0] F_B3 = {8'h23, 8'h50, 8'h42, 8'h2D, 8'h33, 8'h23, 8'h00};
  localparam logic [55:0] F_C0 = {8'h23, 8'h46, 8'h43, 8'h2D, 8'h30, 8'h23, 8'h00};
`endif

  logic       clk_50M;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_type;
  logic [1:0] cmd_loc;
  logic       cmd_ready;
  logic       tx_done;
  logic       data_send;
  logic [7:0] msg;
  logic       busy;
  logic [7:0] frames_sent;

  int checks = 0;
  int errors = 0;

  cmd_msg_encoder #(.GAP_CYCLES(GAP)) dut (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_type    (cmd_type),
    .cmd_loc     (cmd_loc),
    .cmd_ready   (cmd_ready),
    .tx_done     (tx_done),
    .data_send   (data_send),
    .msg         (msg),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  initial begin
    #(1_500_000);
    $display("FAIL watchdog: bench did not reach its summary (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame built from the command fields.
  function automatic logic [55:0] model_frame(input logic [1:0] t, input logic [1:0] l);
    logic [7:0] c;
    logic [7:0] u;
    logic [7:0] lb;
    logic [7:0] cs;
    c  = (t == 2'b11) ? 8'h50 : 8'h46;
    u  = (t == 2'b00) ? 8'h45 : (t == 2'b01) ? 8'h43 : (t == 2'b10) ? 8'h52 : 8'h42;
    lb = 8'h30 + {6'd0, l};
    cs = 8'h40 | ((c ^ u ^ 8'h2D ^ lb) & 8'h3F);
`ifdef CMD_MSG_CHECKSUM_EN
    return {8'h23, c, u, 8'h2D, lb, cs, 8'h23};
`else
    cs = 8'h00;
    return {8'h23, c, u, 8'h2D, lb, 8'h23, cs};
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; tx_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_send(input string tag, output int cyc);
    cyc = 0;
    while (data_send !== 1'b1 && cyc < MAXW) begin
      tick();
      cyc++;
    end
    if (data_send !== 1'b1) chk({tag, " send_timeout"}, 32'(data_send), 32'd1);
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [1:0] l);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < MAXW) begin
      tick();
      w++;
    end
    if (cmd_ready !== 1'b1) chk("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_type = t; cmd_loc = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Plays uart_tx for one whole frame: tx_done dly cycles after each launch.
  // dbl_at: byte whose tx_done is held for two cycles; inj_at: byte during which a new command is offered.
  task automatic expect_frame(input string tag, input logic [55:0] fr, input int dly,
                              input int dbl_at, input int inj_at,
                              input logic [1:0] inj_type, input logic [1:0] inj_loc);
    int         cyc;
    bit         launched;
    logic [7:0] b;
    logic [7:0] nb;
    logic [55:0] f;
    f = fr;
    launched = 1'b0;
    for (int i = 0; i < N; i++) begin
      b = f[55-8*i -: 8];
      if (!launched) begin
        wait_send(tag, cyc);
        if (cyc >= MAXW) return;
        chk($sformatf("%s byte%0d", tag, i), 32'(msg), 32'(b));
      end
      for (int k = 0; k < dly; k++) begin
        if (i == inj_at && k == 0) begin cmd_valid = 1'b1; cmd_type = inj_type; cmd_loc = inj_loc; end
        if (i == inj_at && k == 1) begin cmd_valid = 1'b1; cmd_type = 2'b01; cmd_loc = 2'd0; end
        tick();
        cmd_valid = 1'b0;
        if (k == 0 && !launched) chk($sformatf("%s strobe_len%0d", tag, i), 32'(data_send), 32'd0);
        if (i == inj_at && k == 0) chk($sformatf("%s ready_drop", tag), 32'(cmd_ready), 32'd0);
      end
      chk($sformatf("%s stable%0d", tag, i), 32'(msg), 32'(b));
      chk($sformatf("%s busy%0d", tag, i), 32'(busy), 32'd1);
      launched = 1'b0;
      tx_done = 1'b1;
      tick();
      if (i == dbl_at && i < N - 1) begin
        nb = f[55-8*(i+1) -: 8];
        chk($sformatf("%s dbl_send", tag), 32'(data_send), 32'd1);
        chk($sformatf("%s dbl_msg", tag), 32'(msg), 32'(nb));
        tick();
        chk($sformatf("%s dbl_strobe", tag), 32'(data_send), 32'd0);
        chk($sformatf("%s dbl_hold", tag), 32'(msg), 32'(nb));
        launched = 1'b1;
      end
      tx_done = 1'b0;
    end
    $display("frame %s sent, frames_sent=%0d", tag, frames_sent);
  endtask

  initial begin
    int lat;
    int cyc;
    logic [55:0] fc;
    logic [7:0]  b;

    reset = 1'b1; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_loc = 2'd0; tx_done = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_send", 32'(data_send), 32'd0);
    chk("rst_msg", 32'(msg), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frames", 32'(frames_sent), 32'd0);
    reset = 1'b0;
    tick();

    // EU fault at location 1, tx_done 10 cycles after each launch
    chk("s1_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_type = 2'b00; cmd_loc = 2'd1; lat = 0;
    tick();
    lat++;
    cmd_valid = 1'b0;
    chk("s1_ready_low", 32'(cmd_ready), 32'd0);
    chk("s1_idle_busy", 32'(busy), 32'd0);
    while (data_send !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    chk("s1_latency", 32'(lat), 32'd2);
    expect_frame("s1", F_E1, 10, -1, -1, 2'b00, 2'd0);
    chk("s1_frames", 32'(frames_sent), 32'd1);
    chk("s1_gap_busy", 32'(busy), 32'd1);

    // Pick at location 3; a second pick is queued mid-frame and a third offer is refused
    send_cmd(2'b11, 2'd3);
    expect_frame("s3a", F_B3, 10, -1, 1, 2'b11, 2'd3);
    chk("s3a_frames", 32'(frames_sent), 32'd2);
    wait_send("s3gap", cyc);
    chk("s3_gap_len", 32'(cyc), 32'(GAP + 1));
    expect_frame("s3b", F_B3, 3, -1, -1, 2'b00, 2'd0);
    chk("s3b_frames", 32'(frames_sent), 32'd3);
    chk("s3b_ready", 32'(cmd_ready), 32'd1);

    // Spurious tx_done in IDLE and GAP, double tx_done in WAIT_DONE
    do_reset();
    chk("s4_rst_frames", 32'(frames_sent), 32'd0);
    for (int p = 0; p < 3; p++) begin
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
    end
    chk("s4_idle_busy", 32'(busy), 32'd0);
    chk("s4_idle_send", 32'(data_send), 32'd0);
    chk("s4_idle_msg", 32'(msg), 32'd0);
    send_cmd(2'b00, 2'd1);
    expect_frame("s4a", F_E1, 3, 2, -1, 2'b00, 2'd0);
    chk("s4a_frames", 32'(frames_sent), 32'd1);
    tick();
    tx_done = 1'b1;
    tick();
    tick();
    tx_done = 1'b0;
    chk("s4_gap_busy", 32'(busy), 32'd1);
    chk("s4_gap_send", 32'(data_send), 32'd0);
    chk("s4_gap_frames", 32'(frames_sent), 32'd1);
    send_cmd(2'b00, 2'd1);
    wait_send("s4gap", cyc);
    chk("s4_gap_len", 32'(cyc), 32'(GAP + 1 - 4));
    expect_frame("s4b", F_E1, 2, -1, -1, 2'b00, 2'd0);
    chk("s4b_frames", 32'(frames_sent), 32'd2);

    // Reset after the third launch, with a command pending and tx_done/cmd_valid high
    do_reset();
    send_cmd(2'b01, 2'd0);
    fc = F_C0;
    for (int i = 0; i < 3; i++) begin
      wait_send("s5", cyc);
      b = fc[55-8*i -: 8];
      chk($sformatf("s5 byte%0d", i), 32'(msg), 32'(b));
      if (i < 2) begin
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
      end
    end
    cmd_valid = 1'b1; cmd_type = 2'b10; cmd_loc = 2'd2;
    tick();
    cmd_valid = 1'b0;
    chk("s5_pend", 32'(cmd_ready), 32'd0);
    reset = 1'b1; tx_done = 1'b1; cmd_valid = 1'b1; cmd_type = 2'b11;
    tick();
    chk("s5_rst_send", 32'(data_send), 32'd0);
    chk("s5_rst_msg", 32'(msg), 32'd0);
    chk("s5_rst_busy", 32'(busy), 32'd0);
    chk("s5_rst_ready", 32'(cmd_ready), 32'd1);
    chk("s5_rst_frames", 32'(frames_sent), 32'd0);
    reset = 1'b0; tx_done = 1'b0; cmd_valid = 1'b0;
    tick();
    tick();
    chk("s5_post_busy", 32'(busy), 32'd0);
    chk("s5_post_send", 32'(data_send), 32'd0);
    send_cmd(2'b01, 2'd0);
    expect_frame("s5", F_C0, 2, -1, -1, 2'b00, 2'd0);
    chk("s5_frames", 32'(frames_sent), 32'd1);

    // 256 back-to-back frames wrap the frame counter
    do_reset();
    for (int f = 0; f < 256; f++) begin
      send_cmd(2'(f), 2'(f >> 2));
      expect_frame($sformatf("w%0d", f), model_frame(2'(f), 2'(f >> 2)), 1, -1, -1, 2'b00, 2'd0);
      chk($sformatf("w%0d frames", f), 32'(frames_sent), 32'((f + 1) % 256));
    end
    chk("wrap_final", 32'(frames_sent), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
